// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS control FSM with memory-ready stall and timeout; MCU_TRAP_EN enables the TRAP state for illegal opcode/funct
module multicycle_control_unit #(
  parameter int ALU_OP_W    = 4,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic [2:0]          state,
  output logic                mem_timeout
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} st_t;
`ifdef MCU_TRAP_EN
  localparam st_t BAD = TRAP;
`else
  localparam st_t BAD = FETCH;
`endif
  st_t cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0] a4;
  logic is_r, is_lw, is_sw, is_beq, is_j, is_ori, is_lui, op_ok, fn_ok, mem_st, expired, stall;
  assign is_r    = opcode == 6'b000000;
  assign is_lw   = opcode == 6'b100011;
  assign is_sw   = opcode == 6'b101011;
  assign is_beq  = opcode == 6'b000100;
  assign is_j    = opcode == 6'b000010;
  assign is_ori  = opcode == 6'b001101;
  assign is_lui  = opcode == 6'b001111;
  assign op_ok   = is_r | is_lw | is_sw | is_beq | is_j | is_ori | is_lui;
  assign fn_ok   = funct == 6'b100000 || funct == 6'b100010 || funct == 6'b100100 ||
                   funct == 6'b100101 || funct == 6'b101010;
  assign mem_st  = cur == FETCH || cur == MEM;
  assign expired = mem_st && cnt == CNT_W'(TIMEOUT_CYC);
  assign stall   = mem_st && !mem_ready && !expired;
  assign state   = rst ? 3'd0 : cur;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= stall ? cnt + CNT_W'(1) : '0;
    end
  end
  // Outputs are forced low while rst is high so the reset cycle is quiet
  always_comb begin
    nxt = cur;
    a4 = 4'b0000;
    pc_write = 1'b0;
    ir_write = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    mem_timeout = !rst && expired;
    if (!rst) begin
      case (cur)
        FETCH: begin
          alu_src_b = 2'b01;
          mem_read = !expired;
          if (expired) nxt = FETCH;
          else if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          if (is_j) begin
            pc_write = 1'b1;
            pc_src = 2'b10;
            nxt = FETCH;
          end else nxt = op_ok ? EXEC : BAD;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          if (is_r) begin
            a4 = funct == 6'b100010 ? 4'b0001 : funct == 6'b100100 ? 4'b0010 :
                 funct == 6'b100101 ? 4'b0011 : funct == 6'b101010 ? 4'b0100 : 4'b0000;
            nxt = fn_ok ? WB : funct == 6'b000000 ? FETCH : BAD;
          end else if (is_lw || is_sw) begin
            alu_src_b = 2'b10;
            nxt = MEM;
          end else if (is_ori || is_lui) begin
            alu_src_b = 2'b10;
            a4 = is_ori ? 4'b1001 : 4'b1010;
            nxt = WB;
          end else begin
            a4 = 4'b0001;
            pc_write = zero;
            pc_src = 2'b01;
            nxt = FETCH;
          end
        end
        MEM: begin
          i_or_d = 1'b1;
          mem_read = is_lw && !expired;
          mem_write = !is_lw && !expired;
          if (expired) nxt = FETCH;
          else if (mem_ready) nxt = is_lw ? WB : FETCH;
        end
        WB: begin
          reg_write = 1'b1;
          mem_to_reg = is_lw;
          reg_dst = is_r;
          nxt = FETCH;
        end
        default: nxt = cur == TRAP ? TRAP : FETCH;
      endcase
    end
    alu_op = ALU_OP_W'(a4);
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle vector table with a scoreboard queue for multicycle_control_unit
module tb_multicycle_control_unit;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, mem_timeout;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op;
  logic [2:0] state;
  int n_run = 0, n_fail = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02, ORI = 6'h0D, LUI = 6'h0F, ILL = 6'h3F;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;
  // enable order: pc_write ir_write i_or_d mem_read mem_write reg_write reg_dst mem_to_reg
  localparam logic [7:0] E0 = 8'b0, FE = 8'b11010000, FS = 8'b00010000, ML = 8'b00110000, MS = 8'b00101000;
  localparam logic [7:0] WR = 8'b00000110, WL = 8'b00000101, WI = 8'b00000100, PW = 8'b10000000;

  typedef struct {
    logic r; logic [5:0] op; logic [5:0] fn; logic z; logic rdy;
    logic [2:0] st; logic [7:0] en; logic [1:0] b; logic [3:0] a; logic [1:0] p; logic to;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t v(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                             logic [2:0] st, logic [7:0] en, logic [1:0] b, logic [3:0] a, logic [1:0] p, logic to);
    vec_t t;
    t.r = r; t.op = op; t.fn = fn; t.z = z; t.rdy = rdy;
    t.st = st; t.en = en; t.b = b; t.a = a; t.p = p; t.to = to;
    return t;
  endfunction

  task automatic add(input vec_t t, input int reps = 1);
    for (int i = 0; i < reps; i++) tbl.push_back(t);
  endtask

  // Plain instruction with no wait states: fetch, decode, exec (+mem/wb as given)
  task automatic instr_r(input logic [5:0] fn, input logic [3:0] a);
    add(v(0, R, fn, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, R, fn, 0, 0, 1, E0, 3, 0, 0, 0));
    add(v(0, R, fn, 0, 1, 2, E0, 0, a, 0, 0));
    add(v(0, R, fn, 0, 1, 4, WR, 0, 0, 0, 0));
  endtask

  task automatic chk();
    vec_t e;
    logic [19:0] act, exp;
    if (sb.size() == 0) begin
      n_run++; n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
      return;
    end
    e = sb.pop_front();
    act = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_b, alu_op, pc_src, mem_timeout};
    exp = {e.st, e.en, e.b, e.a, e.p, e.to};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL outputs at %0t op=%h fn=%h: got %h expected %h", $time, e.op, e.fn, act, exp);
    end
    if (!e.r && (e.st == 3'd0 || e.st == 3'd1 || (e.st == 3'd2 && e.op == R))) begin
      n_run++;
      if (alu_src_a !== (e.st == 3'd2)) begin
        n_fail++;
        $display("FAIL alu_src_a at %0t state=%0d: got %b expected %b", $time, e.st, alu_src_a, e.st == 3'd2);
      end
    end
  endtask

  initial begin
    // reset 2 cycles with mem_ready high, then R-type ADD
    add(v(1, R, F_ADD, 0, 1, 0, E0, 0, 0, 0, 0), 2);
    instr_r(F_ADD, 4'b0000);
    // LW with three wait states in MEM
    add(v(0, LW, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, LW, 0, 0, 0, 1, E0, 3, 0, 0, 0));
    add(v(0, LW, 0, 0, 0, 2, E0, 2, 0, 0, 0));
    add(v(0, LW, 0, 0, 0, 3, ML, 0, 0, 0, 0), 3);
    add(v(0, LW, 0, 0, 1, 3, ML, 0, 0, 0, 0));
    add(v(0, LW, 0, 0, 1, 4, WL, 0, 0, 0, 0));
    // BEQ taken then not taken
    add(v(0, BEQ, 0, 1, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, BEQ, 0, 1, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, BEQ, 0, 1, 1, 2, PW, 0, 1, 1, 0));
    add(v(0, BEQ, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, BEQ, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, BEQ, 0, 0, 1, 2, E0, 0, 1, 1, 0));
    // SW with one fetch wait state
    add(v(0, SW, 0, 0, 0, 0, FS, 1, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 2, E0, 2, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 3, MS, 0, 0, 0, 0));
    // ORI, LUI
    add(v(0, ORI, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, ORI, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, ORI, 0, 0, 1, 2, E0, 2, 4'b1001, 0, 0));
    add(v(0, ORI, 0, 0, 1, 4, WI, 0, 0, 0, 0));
    add(v(0, LUI, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, LUI, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, LUI, 0, 0, 1, 2, E0, 2, 4'b1010, 0, 0));
    add(v(0, LUI, 0, 0, 1, 4, WI, 0, 0, 0, 0));
    // J
    add(v(0, J, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, J, 0, 0, 1, 1, PW, 3, 0, 2, 0));
    // remaining R-type ops and NOP (no WB)
    instr_r(F_SUB, 4'b0001);
    instr_r(F_AND, 4'b0010);
    instr_r(F_OR, 4'b0011);
    instr_r(F_SLT, 4'b0100);
    add(v(0, R, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, R, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, R, 0, 0, 1, 2, E0, 0, 0, 0, 0));
    // rst during SW stall, then counter restarts from 0: 15 stalls then timeout
    add(v(0, SW, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, SW, 0, 0, 1, 2, E0, 2, 0, 0, 0));
    add(v(0, SW, 0, 0, 0, 3, MS, 0, 0, 0, 0), 2);
    add(v(1, SW, 0, 0, 0, 0, E0, 0, 0, 0, 0));
    add(v(0, SW, 0, 0, 0, 0, FS, 1, 0, 0, 0), 15);
    add(v(0, SW, 0, 0, 0, 0, E0, 1, 0, 0, 1));
    add(v(0, SW, 0, 0, 0, 0, FS, 1, 0, 0, 0));
    // LW timeout in MEM
    add(v(0, LW, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, LW, 0, 0, 1, 1, E0, 3, 0, 0, 0));
    add(v(0, LW, 0, 0, 1, 2, E0, 2, 0, 0, 0));
    add(v(0, LW, 0, 0, 0, 3, ML, 0, 0, 0, 0), 15);
    add(v(0, LW, 0, 0, 0, 3, 8'b00100000, 0, 0, 0, 1));
    add(v(0, LW, 0, 0, 0, 0, FS, 1, 0, 0, 0));
    // illegal opcode
    add(v(0, ILL, 0, 0, 1, 0, FE, 1, 0, 0, 0));
    add(v(0, ILL, 0, 0, 1, 1, E0, 3, 0, 0, 0));
`ifdef MCU_TRAP_EN
    add(v(0, ILL, 0, 0, 1, 5, E0, 0, 0, 0, 0), 4);
    add(v(1, ILL, 0, 0, 1, 0, E0, 0, 0, 0, 0));
    add(v(0, R, F_ADD, 0, 0, 0, FS, 1, 0, 0, 0));
`else
    add(v(0, R, F_ADD, 0, 0, 0, FS, 1, 0, 0, 0));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].r; opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      @(negedge clk);
      chk();
    end
    if (sb.size() != 0) begin
      n_run++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
